// File: rtl/boot_pkg.sv
// Shared boot-path definitions: status codes,
// checker states and a byte-wide CRC-16 step.
package boot_pkg;

  localparam logic [7:0] ST_IDLE    = 8'h00;
  localparam logic [7:0] ST_BUSY    = 8'h01;
  localparam logic [7:0] ST_PASS    = 8'h02;
  localparam logic [7:0] ST_FAIL    = 8'h03;
  localparam logic [7:0] ST_LEN_ERR = 8'h04;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // MSB-first, non-reflected CRC over one byte
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  data,
    input logic [15:0] poly
  );
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

endpackage

// File: rtl/dpm_crc_checker_if.sv
// Control handshake and RAM read port
// between the main FSM side and the checker.
interface dpm_crc_checker_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic              in_process;
  logic              done;
  logic [7:0]        status;
  logic [15:0]       crc_o;
  logic [15:0]       crc_exp_o;

  modport master (
    output start, base_addr, len, rd_data,
    input  rd_addr, rd_en, in_process,
    input  done, status, crc_o, crc_exp_o
  );

  modport slave (
    input  start, base_addr, len, rd_data,
    output rd_addr, rd_en, in_process,
    output done, status, crc_o, crc_exp_o
  );
endinterface

// File: rtl/crc16_byte_unit.sv
// Combinational CRC-16 update for one byte,
// MSB-first with a configurable polynomial.
module crc16_byte_unit
  import boot_pkg::*;
#(
  parameter logic [15:0] POLY = 16'h1021
) (
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  // one byte worth of polynomial division
  always_comb begin
    crc_next = crc16_byte(crc, data, POLY);
  end

endmodule

// File: rtl/dpm_crc_checker.sv
// Streams a RAM region through CRC-16 and
// compares it with the trailing stored CRC.
module dpm_crc_checker
  import boot_pkg::*;
#(
  parameter int          ADDR_W   = 9,
  parameter logic [15:0] CRC_POLY = 16'h1021,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input logic              clk,
  input logic              rst,
  dpm_crc_checker_if.slave bus
);

  localparam int CW = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_en_q;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     ret_idx;
  logic              vld;
  logic [15:0]       crc;
  logic [15:0]       crc_next;
  logic [7:0]        exp_hi;
  logic              in_proc_q;
  logic              done_q;
  logic [7:0]        status_q;
  logic [15:0]       crc_q;
  logic [15:0]       crc_exp_q;
  logic              len_ok;
  logic [CW-1:0]     len_w;
  logic [15:0]       exp_full;

  assign len_ok   = (bus.len != '0) && (bus.len != '1);
  assign len_w    = {1'b0, len_q};
  assign exp_full = {exp_hi, bus.rd_data};

  crc16_byte_unit #(
    .POLY(CRC_POLY)
  ) u_crc (
    .crc     (crc),
    .data    (bus.rd_data),
    .crc_next(crc_next)
  );

  // FSM, address issue, return tagging, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      issue_cnt <= '0;
      ret_idx   <= '0;
      vld       <= 1'b0;
      crc       <= '0;
      exp_hi    <= '0;
      in_proc_q <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= ST_IDLE;
      crc_q     <= '0;
      crc_exp_q <= '0;
    end else begin
      done_q <= 1'b0;
      vld    <= rd_en_q;
      if (vld) begin
        ret_idx <= ret_idx + CW'(1);
        if (ret_idx < len_w) begin
          crc <= crc_next;
        end else if (ret_idx == len_w) begin
          exp_hi <= bus.rd_data;
        end
      end
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (len_ok) begin
              len_q     <= bus.len;
              rd_addr_q <= bus.base_addr;
              rd_en_q   <= 1'b1;
              issue_cnt <= '0;
              ret_idx   <= '0;
              crc       <= CRC_INIT;
              status_q  <= ST_BUSY;
              in_proc_q <= 1'b1;
              state     <= S_READ;
            end else begin
              status_q <= ST_LEN_ERR;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (issue_cnt == len_w + CW'(1)) begin
            rd_en_q <= 1'b0;
            state   <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
            issue_cnt <= issue_cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          crc_q     <= crc;
          crc_exp_q <= exp_full;
          status_q  <= (crc == exp_full) ? ST_PASS
                                         : ST_FAIL;
          in_proc_q <= 1'b0;
          done_q    <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.in_process = in_proc_q;
  assign bus.done       = done_q;
  assign bus.status     = status_q;
  assign bus.crc_o      = crc_q;
  assign bus.crc_exp_o  = crc_exp_q;

endmodule
